// File: rtl/jtdd2_main_com_pkg.sv
// Shared definitions for the main<->sub communication link: FSM states,
// control register bit positions and the decoded control-write payload.
package jtdd2_main_com_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_GRANT = 2'd2,
        ST_REL   = 2'd3
    } com_state_t;

    localparam int unsigned CTL_HALT    = 0;
    localparam int unsigned CTL_NMI     = 1;
    localparam int unsigned CTL_IRQCLR  = 2;
    localparam int unsigned CTL_TOUTCLR = 3;
    localparam int unsigned CTL_W       = 4;
    localparam int unsigned NMI_CNT_W   = 4;

    typedef struct packed {
        logic wr;        // a control write happened this tick
        logic halt;      // value written to the stored halt request
        logic nmi;       // fire NMI pulse
        logic irq_clr;   // clear main IRQ
        logic tout_clr;  // clear timeout flag
    } ctl_ev_t;

    function automatic ctl_ev_t ctl_decode(input logic ev, input logic [CTL_W-1:0] d);
        ctl_ev_t c;
        c.wr       = ev;
        c.halt     = d[CTL_HALT];
        c.nmi      = ev & d[CTL_NMI];
        c.irq_clr  = ev & d[CTL_IRQCLR];
        c.tout_clr = ev & d[CTL_TOUTCLR];
        return c;
    endfunction

endpackage

// File: rtl/jtdd2_com_pulse.sv
// Clock-enable gated pulse stretcher: a trigger starts a LEN-tick pulse;
// triggers arriving while the pulse is running are ignored.
module jtdd2_com_pulse
    import jtdd2_main_com_pkg::*;
#(
    parameter int unsigned LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic cen,
    input  logic trig,
    output logic pulse
);

    logic [NMI_CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            pulse <= 1'b0;
        end else if (cen) begin
            if (cnt != '0) begin
                cnt   <= cnt - NMI_CNT_W'(1);
                pulse <= (cnt != NMI_CNT_W'(1));
            end else if (trig) begin
                cnt   <= NMI_CNT_W'(LEN);
                pulse <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/jtdd2_main_com.sv
// Main-CPU side of the main<->sub link: sub bus request/grant handshake,
// shared-RAM window gating, NMI to the sub and latched IRQ from the sub.
module jtdd2_main_com
    import jtdd2_main_com_pkg::*;
#(
    parameter int unsigned TOUT_W  = 12,
    parameter int unsigned NMI_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       main_cen,
    input  logic       ctrl_cs,
    input  logic       com_cs,
    input  logic       main_wrn,
    input  logic [7:0] main_dout,
    input  logic       irq_clr,
    input  logic       mcu_ban,
    input  logic       mcu_irqmain,
    output logic       mcu_halt,
    output logic       mcu_nmi_set,
    output logic       main_irq,
    output logic       main_wait,
    output logic       com_ok,
    output logic [7:0] status_dout
);

    com_state_t        state;
    logic [TOUT_W-1:0] tcnt;
    logic [TOUT_W-1:0] tcnt_inc;
    logic              ban_m, ban_s;
    logic              wr_prev, irqm_prev;
    logic              halt_req, tout;
    logic              wr_lvl, wr_ev, tout_hit, irq_rise, irq_clr_ev;
    ctl_ev_t           ctl;
    logic              unused_dout;

    assign unused_dout = ^main_dout[7:CTL_W];

    // One write event per bus cycle: rising edge of the select/strobe level
    assign wr_lvl = ctrl_cs & ~main_wrn;
    assign wr_ev  = main_cen & wr_lvl & ~wr_prev;
    assign ctl    = ctl_decode(wr_ev, main_dout[CTL_W-1:0]);

    // Timeout fires on the tick the request counter reaches all-ones
    assign tcnt_inc = tcnt + TOUT_W'(1);
    assign tout_hit = main_cen & (state == ST_REQ) & ban_s & halt_req & (&tcnt_inc);

    assign irq_rise   = main_cen & mcu_irqmain & ~irqm_prev;
    assign irq_clr_ev = main_cen & (irq_clr | ctl.irq_clr);

    assign main_wait   = com_cs & (state == ST_REQ);
    assign status_dout = {tout, main_irq, mcu_nmi_set, 2'b00, ban_s, com_ok, halt_req};

    always_ff @(posedge clk) begin
        if (rst) begin
            ban_m <= 1'b1;
            ban_s <= 1'b1;
        end else begin
            ban_m <= mcu_ban;
            ban_s <= ban_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_prev   <= 1'b0;
            irqm_prev <= 1'b0;
            halt_req  <= 1'b0;
            tout      <= 1'b0;
            main_irq  <= 1'b0;
        end else if (main_cen) begin
            wr_prev   <= wr_lvl;
            irqm_prev <= mcu_irqmain;
            // A fresh write reflects newer intent than a concurrent timeout
            if (ctl.wr)
                halt_req <= ctl.halt;
            else if (tout_hit)
                halt_req <= 1'b0;
            if (tout_hit)
                tout <= 1'b1;
            else if (ctl.tout_clr)
                tout <= 1'b0;
            if (irq_rise)
                main_irq <= 1'b1;
            else if (irq_clr_ev)
                main_irq <= 1'b0;
        end
    end

    // Bus request FSM; mcu_halt and com_ok are registered with the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            tcnt     <= '0;
            mcu_halt <= 1'b0;
            com_ok   <= 1'b0;
        end else if (main_cen) begin
            case (state)
                ST_IDLE: begin
                    if (halt_req) begin
                        state    <= ST_REQ;
                        tcnt     <= '0;
                        mcu_halt <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (!ban_s) begin
                        state  <= ST_GRANT;
                        com_ok <= 1'b1;
                    end else if (!halt_req) begin
                        state    <= ST_REL;
                        mcu_halt <= 1'b0;
                    end else begin
                        tcnt <= tcnt_inc;
                        if (tout_hit) begin
                            state    <= ST_REL;
                            mcu_halt <= 1'b0;
                        end
                    end
                end
                ST_GRANT: begin
                    if (!halt_req) begin
                        state    <= ST_REL;
                        mcu_halt <= 1'b0;
                        com_ok   <= 1'b0;
                    end else if (ban_s) begin
                        state  <= ST_REQ;
                        tcnt   <= '0;
                        com_ok <= 1'b0;
                    end
                end
                ST_REL: begin
                    if (ban_s)
                        state <= ST_IDLE;
                end
                default: begin
                    state    <= ST_IDLE;
                    mcu_halt <= 1'b0;
                    com_ok   <= 1'b0;
                end
            endcase
        end
    end

    jtdd2_com_pulse #(
        .LEN (NMI_LEN)
    ) u_nmi (
        .clk   (clk),
        .rst   (rst),
        .cen   (main_cen),
        .trig  (ctl.nmi),
        .pulse (mcu_nmi_set)
    );

endmodule
